// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Build option HAZARD_STALL_STATS_EN is handled in the top module.
package pipeline_ctrl_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MD_BUSY = 1'b1
   } state_e;

   localparam logic [4:0] REG_ZERO               = 5'd0;
   localparam int         MULDIV_LATENCY_DEFAULT = 32;

   typedef struct packed {
      logic pc_hold;
      logic ifid_hold;
      logic idex_hold;
      logic exmem_hold;
      logic ifid_flush;
      logic idex_bubble;
      logic exmem_bubble;
      logic memwb_bubble;
      logic muldiv_start;
      logic muldiv_done;
   } hz_ctl_t;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-status inputs and stall/flush controls exchanged between the
// pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_controller_if;
   logic [4:0] ID_ADDR1;
   logic [4:0] ID_ADDR2;
   logic       ID_USES1;
   logic       ID_USES2;
   logic [4:0] EX_ADDR;
   logic       EX_MEMREAD;
   logic       EX_MULDIV;
   logic       BJ_TAKEN;
   logic       DMEM_BUSY;

   logic       PC_HOLD;
   logic       IFID_HOLD;
   logic       IDEX_HOLD;
   logic       EXMEM_HOLD;
   logic       IFID_FLUSH;
   logic       IDEX_BUBBLE;
   logic       EXMEM_BUBBLE;
   logic       MEMWB_BUBBLE;
   logic       MULDIV_START;
   logic       MULDIV_DONE;

   modport master (
      output ID_ADDR1, ID_ADDR2, ID_USES1, ID_USES2, EX_ADDR,
             EX_MEMREAD, EX_MULDIV, BJ_TAKEN, DMEM_BUSY,
      input  PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD, IFID_FLUSH,
             IDEX_BUBBLE, EXMEM_BUBBLE, MEMWB_BUBBLE, MULDIV_START, MULDIV_DONE
   );

   modport slave (
      input  ID_ADDR1, ID_ADDR2, ID_USES1, ID_USES2, EX_ADDR,
             EX_MEMREAD, EX_MULDIV, BJ_TAKEN, DMEM_BUSY,
      output PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD, IFID_FLUSH,
             IDEX_BUBBLE, EXMEM_BUBBLE, MEMWB_BUBBLE, MULDIV_START, MULDIV_DONE
   );
endinterface

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Combinational load-use check: the load in EX writes a register the ID
// instruction reads. x0 is hardwired, so it never creates a dependency.
module load_use_detector
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] id_addr1_i,
   input  logic [4:0] id_addr2_i,
   input  logic       id_uses1_i,
   input  logic       id_uses2_i,
   input  logic [4:0] ex_addr_i,
   input  logic       ex_memread_i,
   output logic       lu_o
);

   logic hit1;
   logic hit2;

   assign hit1 = id_uses1_i & (id_addr1_i == ex_addr_i);
   assign hit2 = id_uses2_i & (id_addr2_i == ex_addr_i);
   assign lu_o = ex_memread_i & (ex_addr_i != REG_ZERO) & (hit1 | hit2);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, iterative divide,
// data-memory wait and branch flush. HAZARD_STALL_STATS_EN adds stall/flush counters.
//
//  state   | meaning
//  IDLE    | no divide in flight; DMEM/branch/load-use hazards handled directly
//  MD_BUSY | divide occupying EX; count = cycles left before the result is valid
module pipeline_hazard_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEFAULT,
   parameter int CNT_W          = 8
) (
   input  logic                         CLK,
   input  logic                         RESET,
   pipeline_hazard_controller_if.slave  hz
`ifdef HAZARD_STALL_STATS_EN
   ,
   output logic [31:0]                  STALL_CYCLES,
   output logic [31:0]                  FLUSH_COUNT
`endif
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   hz_ctl_t          ctl;
   hz_ctl_t          ctl_out;
   logic             lu;

   load_use_detector u_lu (
      .id_addr1_i   (hz.ID_ADDR1),
      .id_addr2_i   (hz.ID_ADDR2),
      .id_uses1_i   (hz.ID_USES1),
      .id_uses2_i   (hz.ID_USES2),
      .ex_addr_i    (hz.EX_ADDR),
      .ex_memread_i (hz.EX_MEMREAD),
      .lu_o         (lu)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      ctl     = '0;
      state_d = state_q;
      count_d = count_q;

      // The divider runs regardless of memory stalls, so the count always ticks.
      if (state_q == MD_BUSY && count_q != '0) begin
         count_d = count_q - CNT_ONE;
      end

      if (hz.DMEM_BUSY) begin
         ctl.pc_hold      = 1'b1;
         ctl.ifid_hold    = 1'b1;
         ctl.idex_hold    = 1'b1;
         ctl.exmem_hold   = 1'b1;
         ctl.memwb_bubble = 1'b1;
      end else if (state_q == MD_BUSY) begin
         if (count_q != '0) begin
            ctl.pc_hold      = 1'b1;
            ctl.ifid_hold    = 1'b1;
            ctl.idex_hold    = 1'b1;
            ctl.exmem_bubble = 1'b1;
         end else begin
            ctl.muldiv_done = 1'b1;
            state_d         = IDLE;
         end
      end else if (hz.EX_MULDIV) begin
         ctl.muldiv_start = 1'b1;
         ctl.pc_hold      = 1'b1;
         ctl.ifid_hold    = 1'b1;
         ctl.idex_hold    = 1'b1;
         ctl.exmem_bubble = 1'b1;
         count_d          = CNT_LOAD;
         state_d          = MD_BUSY;
      end else if (hz.BJ_TAKEN) begin
         ctl.ifid_flush  = 1'b1;
         ctl.idex_bubble = 1'b1;
      end else if (lu) begin
         ctl.pc_hold     = 1'b1;
         ctl.ifid_hold   = 1'b1;
         ctl.idex_bubble = 1'b1;
      end
   end

   // Keep the divider and pipeline quiet while reset is held, whatever the inputs.
   assign ctl_out = RESET ? '0 : ctl;

   assign hz.PC_HOLD      = ctl_out.pc_hold;
   assign hz.IFID_HOLD    = ctl_out.ifid_hold;
   assign hz.IDEX_HOLD    = ctl_out.idex_hold;
   assign hz.EXMEM_HOLD   = ctl_out.exmem_hold;
   assign hz.IFID_FLUSH   = ctl_out.ifid_flush;
   assign hz.IDEX_BUBBLE  = ctl_out.idex_bubble;
   assign hz.EXMEM_BUBBLE = ctl_out.exmem_bubble;
   assign hz.MEMWB_BUBBLE = ctl_out.memwb_bubble;
   assign hz.MULDIV_START = ctl_out.muldiv_start;
   assign hz.MULDIV_DONE  = ctl_out.muldiv_done;

`ifdef HAZARD_STALL_STATS_EN
   logic [31:0] stall_q, stall_d;
   logic [31:0] flush_q, flush_d;

   assign stall_d = stall_q + {31'd0, ctl_out.pc_hold};
   assign flush_d = flush_q + {31'd0, ctl_out.ifid_flush};

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign STALL_CYCLES = stall_q;
   assign FLUSH_COUNT  = flush_q;
`endif

endmodule
